// File: rtl/rf_writeback_arbiter_if.sv
// rf_writeback_arbiter_if: producer handshakes, register-file write port and pending lookup
interface rf_writeback_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int QDEPTH = 4
);
  logic alu_wr;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic ld_valid;
  logic ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic md_valid;
  logic md_ready;
  logic [AW-1:0] md_addr;
  logic [DW-1:0] md_data;
  logic rf_wr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [AW-1:0] pend_addr;
  logic pend_hit;
  logic [$clog2(QDEPTH):0] q_count;
  modport master (
    output alu_wr, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
           md_valid, md_addr, md_data, pend_addr,
    input ld_ready, md_ready, rf_wr, rf_addr, rf_data, pend_hit, q_count
  );
  modport slave (
    input alu_wr, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
          md_valid, md_addr, md_data, pend_addr,
    output ld_ready, md_ready, rf_wr, rf_addr, rf_data, pend_hit, q_count
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges ALU, load and mul/div results onto the single register-file write port
module rf_writeback_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int QDEPTH = 4
) (
  input logic clk,
  input logic reset,
  rf_writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(QDEPTH - 1);
  logic [AW-1:0] q_addr [QDEPTH];
  logic [DW-1:0] q_data [QDEPTH];
  logic [PW-1:0] rd, wr, md_idx;
  logic [CW-1:0] count;
  logic alu_take, ld_push, md_push, pop, hit;
  assign bus.ld_ready = count < FULL;
  // md must leave room for a same-cycle load, which is the older result
  assign bus.md_ready = bus.ld_valid ? count < ALMOST : count < FULL;
  assign alu_take = bus.alu_wr && bus.alu_addr != '0;
  assign ld_push = bus.ld_valid && bus.ld_ready && bus.ld_addr != '0;
  assign md_push = bus.md_valid && bus.md_ready && bus.md_addr != '0;
  assign pop = !alu_take && count != '0;
  assign md_idx = wr + PW'(ld_push);
  assign bus.q_count = count;
  assign bus.pend_hit = hit;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < QDEPTH; i++)
      if ({1'b0, PW'(i) - rd} < count && q_addr[i] == bus.pend_addr) hit = 1'b1;
    hit = hit && bus.pend_addr != '0;
  end
  always_ff @(posedge clk) begin
    if (ld_push) begin
      q_addr[wr] <= bus.ld_addr;
      q_data[wr] <= bus.ld_data;
    end
    if (md_push) begin
      q_addr[md_idx] <= bus.md_addr;
      q_data[md_idx] <= bus.md_data;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      bus.rf_wr <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_data <= '0;
    end else begin
      wr <= wr + PW'(ld_push) + PW'(md_push);
      rd <= rd + PW'(pop);
      count <= count + CW'(ld_push) + CW'(md_push) - CW'(pop);
      bus.rf_wr <= alu_take || pop;
      if (alu_take) begin
        bus.rf_addr <= bus.alu_addr;
        bus.rf_data <= bus.alu_data;
      end else if (pop) begin
        bus.rf_addr <= q_addr[rd];
        bus.rf_data <= q_data[rd];
      end
    end
  end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed vectors with hand-computed expectations
module tb_rf_writeback_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  rf_writeback_arbiter_if #(.DW(32), .AW(5), .QDEPTH(4)) bus ();
  rf_writeback_arbiter #(.DW(32), .AW(5), .QDEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.alu_wr = 0; bus.alu_addr = 0; bus.alu_data = 0;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0;
    bus.md_valid = 0; bus.md_addr = 0; bus.md_data = 0;
  endtask
  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    bus.alu_wr = 1; bus.alu_addr = a; bus.alu_data = d;
  endtask
  task automatic ld(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.ld_valid = v; bus.ld_addr = a; bus.ld_data = d;
  endtask
  task automatic md(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.md_valid = v; bus.md_addr = a; bus.md_data = d;
  endtask
  task automatic wr_is(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wr"}, bus.rf_wr, 1);
    chk({tag, "_addr"}, bus.rf_addr, a);
    chk({tag, "_data"}, bus.rf_data, d);
  endtask
  initial begin
    idle();
    bus.pend_addr = 0;
    step(); step();
    chk("rst_wr", bus.rf_wr, 0);
    chk("rst_addr", bus.rf_addr, 0);
    chk("rst_data", bus.rf_data, 0);
    chk("rst_cnt", bus.q_count, 0);
    reset = 0;
    alu(5, 32'hDEADBEEF);
    step();
    wr_is("alu", 5, 32'hDEADBEEF);
    alu(0, 32'h123);
    step();
    chk("alu0_wr", bus.rf_wr, 0);
    chk("alu0_hold", bus.rf_addr, 5);
    idle();
    ld(1, 8, 32'h11);
    #1 chk("ct_ldrdy", bus.ld_ready, 1);
    step();
    chk("ct_cnt0", bus.q_count, 1);
    chk("ct_nowr", bus.rf_wr, 0);
    idle();
    alu(9, 32'h22);
    step();
    wr_is("ct_a1", 9, 32'h22);
    chk("ct_cnt1", bus.q_count, 1);
    step();
    wr_is("ct_a2", 9, 32'h22);
    chk("ct_cnt2", bus.q_count, 1);
    idle();
    step();
    wr_is("ct_q", 8, 32'h11);
    chk("ct_cnt3", bus.q_count, 0);
    alu(9, 32'h22);
    for (int i = 0; i < 4; i++) begin
      ld(1, 5'(10 + i), 32'(i));
      #1 chk("full_rdy", bus.ld_ready, 1);
      step();
      chk("full_cnt", bus.q_count, i + 1);
    end
    chk("full_ldrdy", bus.ld_ready, 0);
    chk("full_mdrdy", bus.md_ready, 0);
    step();
    chk("full_hold", bus.q_count, 4);
    bus.alu_wr = 0;
    step();
    wr_is("full_p0", 10, 0);
    chk("full_cnt3", bus.q_count, 3);
    chk("full_rdy1", bus.ld_ready, 1);
    idle();
    for (int i = 1; i < 4; i++) begin
      step();
      wr_is("full_p", 5'(10 + i), 32'(i));
    end
    chk("full_empty", bus.q_count, 0);
    ld(1, 1, 32'h1);
    md(1, 2, 32'h2);
    #1 chk("dp_md0", bus.md_ready, 1);
    alu(9, 32'h22);
    step();
    chk("dp_cnt2", bus.q_count, 2);
    ld(1, 3, 32'hA);
    md(1, 4, 32'hB);
    #1 chk("dp_mdrdy2", bus.md_ready, 1);
    step();
    chk("dp_cnt4", bus.q_count, 4);
    idle();
    step(); wr_is("dp_d1", 1, 32'h1);
    step(); wr_is("dp_d2", 2, 32'h2);
    step(); wr_is("dp_d3", 3, 32'hA);
    step(); wr_is("dp_d4", 4, 32'hB);
    chk("dp_cnt0", bus.q_count, 0);
    alu(9, 32'h22);
    ld(1, 1, 32'h1);
    md(1, 2, 32'h2);
    step();
    md(0, 0, 0);
    ld(1, 5, 32'h5);
    step();
    chk("dp3_cnt", bus.q_count, 3);
    ld(1, 6, 32'h6);
    md(1, 7, 32'h7);
    #1 chk("dp3_ldrdy", bus.ld_ready, 1);
    chk("dp3_mdrdy", bus.md_ready, 0);
    step();
    chk("dp3_cnt4", bus.q_count, 4);
    idle();
    step(); wr_is("dp3_d1", 1, 32'h1);
    step(); wr_is("dp3_d2", 2, 32'h2);
    step(); wr_is("dp3_d3", 5, 32'h5);
    step(); wr_is("dp3_d4", 6, 32'h6);
    chk("dp3_cnt0", bus.q_count, 0);
    step();
    chk("dp3_idle", bus.rf_wr, 0);
    alu(9, 32'h22);
    md(1, 0, 32'h99);
    #1 chk("z_rdy", bus.md_ready, 1);
    step();
    chk("z_cnt", bus.q_count, 0);
    md(0, 0, 0);
    ld(1, 7, 32'h77);
    bus.pend_addr = 7;
    #1 chk("pend_pre", bus.pend_hit, 0);
    step();
    ld(0, 0, 0);
    chk("pend_hit", bus.pend_hit, 1);
    bus.pend_addr = 0;
    #1 chk("pend_zero", bus.pend_hit, 0);
    bus.pend_addr = 8;
    #1 chk("pend_other", bus.pend_hit, 0);
    bus.pend_addr = 7;
    step();
    chk("pend_hold", bus.pend_hit, 1);
    idle();
    step();
    wr_is("pend_pop", 7, 32'h77);
    chk("pend_gone", bus.pend_hit, 0);
    step();
    chk("z_never", bus.rf_wr, 0);
    alu(9, 32'h22);
    ld(1, 1, 32'h1);
    md(1, 2, 32'h2);
    step();
    md(0, 0, 0);
    ld(1, 3, 32'h3);
    step();
    chk("mr_cnt", bus.q_count, 3);
    idle();
    reset = 1;
    #1;
    chk("mr_wr", bus.rf_wr, 0);
    chk("mr_addr", bus.rf_addr, 0);
    chk("mr_data", bus.rf_data, 0);
    chk("mr_cnt0", bus.q_count, 0);
    step();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_nowr", bus.rf_wr, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
